// File: rtl/gty_tx_pkg.sv
// gty_tx_pkg: shared constants for the GTY TX framer.
//   - line word type codes and fixed payloads
//   - header field positions inside the 80-bit line word
//   - framer state encoding
package gty_tx_pkg;

    // Line word field positions: [79:72] type, [71:64] beat index, [63:0] payload
    localparam int TYPE_MSB = 79;
    localparam int TYPE_LSB = 72;
    localparam int IDX_MSB  = 71;
    localparam int IDX_LSB  = 64;
    localparam int LINE_W   = 80;

    localparam logic [7:0] T_SYNC = 8'hBC;
    localparam logic [7:0] T_IDLE = 8'h1C;
    localparam logic [7:0] T_SOF  = 8'hFB;
    localparam logic [7:0] T_DATA = 8'hD0;
    localparam logic [7:0] T_EOF  = 8'hFD;
    localparam logic [7:0] T_SOLE = 8'hFE;

    localparam logic [63:0] SYNC_PAYLOAD = 64'hBC50_BC50_BC50_BC50;

    typedef enum logic [1:0] {
        WAIT_LINK = 2'd0,
        ALIGN     = 2'd1,
        RUN       = 2'd2
    } state_e;

    function automatic logic [LINE_W-1:0] line_word(input logic [7:0]  typ,
                                                    input logic [7:0]  idx,
                                                    input logic [63:0] payload);
        logic [LINE_W-1:0] w;
        w                    = '0;
        w[TYPE_MSB:TYPE_LSB] = typ;
        w[IDX_MSB:IDX_LSB]   = idx;
        w[63:0]              = payload;
        return w;
    endfunction

    localparam logic [LINE_W-1:0] IDLE_WORD = {T_IDLE, 8'h00, 64'h0};
    localparam logic [LINE_W-1:0] SYNC_WORD = {T_SYNC, 8'h00, SYNC_PAYLOAD};

endpackage

// File: rtl/gty_tx_framer_sync2.sv
// gty_sync2: two-flop synchroniser for a slow asynchronous level.
//   clk   in  destination clock
//   rst   in  asynchronous active-high reset, clears both flops to 0
//   d_i   in  asynchronous input level
//   q_o   out synchronised level
module gty_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gty_tx_framer.sv
// gty_tx_framer: 64-bit AXI4-Stream to 80-bit GTY TX line words.
//   m_axis_aclk             in  TX user clock
//   reset                   in  asynchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tready  AXI4-Stream sink (tready registered)
//   gtwiz_reset_tx_done     in  async TX reset done (synchronised here)
//   gtwiz_userclk_tx_active in  async TX clock active (synchronised here)
//   gtwiz_userdata_tx       out line word {type, index, payload}
//   link_up                 out high while streaming (RUN)
//   pkt_abort               out one-cycle pulse when the link drops mid-packet
//   beat_count              out accepted beats since reset, wrapping
module gty_tx_framer
    import gty_tx_pkg::*;
#(
    parameter int SYNC_COUNT  = 16,
    parameter int SYNC_PERIOD = 1024,
    parameter int CNT_W       = 32
) (
    input  logic             m_axis_aclk,
    input  logic             reset,
    input  logic [63:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    input  logic             gtwiz_reset_tx_done,
    input  logic             gtwiz_userclk_tx_active,
    output logic [79:0]      gtwiz_userdata_tx,
    output logic             link_up,
    output logic             pkt_abort,
    output logic [CNT_W-1:0] beat_count
);

    localparam int SC_W = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;
    localparam int PC_W = $clog2(SYNC_PERIOD);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SYNC_COUNT - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(SYNC_PERIOD - 1);

    logic tx_done_s, clk_active_s, link_ok;

    gty_sync2 u_sync_done (
        .clk (m_axis_aclk),
        .rst (reset),
        .d_i (gtwiz_reset_tx_done),
        .q_o (tx_done_s)
    );

    gty_sync2 u_sync_active (
        .clk (m_axis_aclk),
        .rst (reset),
        .d_i (gtwiz_userclk_tx_active),
        .q_o (clk_active_s)
    );

    assign link_ok = tx_done_s & clk_active_s;

    state_e            state_q, state_d;
    logic [SC_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic [PC_W-1:0]   period_cnt_q, period_cnt_d;
    logic              in_pkt_q, in_pkt_d;
    logic [7:0]        idx_q, idx_d;
    logic              tready_q, tready_d;
    logic [79:0]       word_q, word_d;
    logic              abort_q, abort_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              accept;
    logic [7:0]        typ;

    assign accept = s_axis_tvalid & tready_q;

    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        period_cnt_d = period_cnt_q;
        in_pkt_d     = in_pkt_q;
        idx_d        = idx_q;
        word_d       = IDLE_WORD;
        abort_d      = 1'b0;
        beat_cnt_d   = beat_cnt_q;
        typ          = T_IDLE;

        case (state_q)
            WAIT_LINK: begin
                if (link_ok) begin
                    state_d    = ALIGN;
                    sync_cnt_d = '0;
                end
            end
            ALIGN: begin
                word_d     = SYNC_WORD;
                sync_cnt_d = sync_cnt_q + 1'b1;
                if (sync_cnt_q == SC_LAST) begin
                    state_d      = RUN;
                    period_cnt_d = '0;
                end
            end
            RUN: begin
                period_cnt_d = (period_cnt_q == PC_LAST) ? '0 : period_cnt_q + 1'b1;
                if (period_cnt_q == PC_LAST) begin
                    // tready was already low for this slot, so nothing is accepted
                    word_d = SYNC_WORD;
                end else if (accept) begin
                    case ({in_pkt_q, s_axis_tlast})
                        2'b00:   typ = T_SOF;
                        2'b01:   typ = T_SOLE;
                        2'b10:   typ = T_DATA;
                        default: typ = T_EOF;
                    endcase
                    idx_d      = in_pkt_q ? idx_q + 8'd1 : 8'd0;
                    in_pkt_d   = ~s_axis_tlast;
                    word_d     = line_word(typ, idx_d, s_axis_tdata);
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = WAIT_LINK;
        endcase

        // Link loss overrides everything; a beat taken this cycle still goes out,
        // but an open packet is abandoned without a synthesised EOF.
        if (!link_ok) begin
            state_d = WAIT_LINK;
            if (in_pkt_d) begin
                abort_d  = 1'b1;
                in_pkt_d = 1'b0;
            end
        end

        // Registered ready: predicts whether the next cycle is a RUN data slot.
        tready_d = (state_d == RUN) && (period_cnt_d != PC_LAST);
    end

    always_ff @(posedge m_axis_aclk or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_LINK;
            sync_cnt_q   <= '0;
            period_cnt_q <= '0;
            in_pkt_q     <= 1'b0;
            idx_q        <= '0;
            tready_q     <= 1'b0;
            word_q       <= IDLE_WORD;
            abort_q      <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            period_cnt_q <= period_cnt_d;
            in_pkt_q     <= in_pkt_d;
            idx_q        <= idx_d;
            tready_q     <= tready_d;
            word_q       <= word_d;
            abort_q      <= abort_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign s_axis_tready     = tready_q;
    assign gtwiz_userdata_tx = word_q;
    assign link_up           = (state_q == RUN);
    assign pkt_abort         = abort_q;
    assign beat_count        = beat_cnt_q;

endmodule

// File: tb/tb_gty_tx_framer.sv
module tb_gty_tx_framer;

    localparam int P     = 8;
    localparam int NSYNC = 16;
    localparam logic [79:0] IDLE_W = 80'h1C00_0000_0000_0000_0000;
    localparam logic [79:0] SYNC_W = 80'hBC00_BC50_BC50_BC50_BC50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic        tx_done = 1'b0;
    logic        clk_act = 1'b0;
    logic [79:0] line;
    logic        link_up;
    logic        pkt_abort;
    logic [31:0] beat_count;

    always #5 clk = ~clk;

    gty_tx_framer #(.SYNC_COUNT(NSYNC), .SYNC_PERIOD(P), .CNT_W(32)) dut (
        .m_axis_aclk             (clk),
        .reset                   (rst),
        .s_axis_tdata            (tdata),
        .s_axis_tvalid           (tvalid),
        .s_axis_tlast            (tlast),
        .s_axis_tready           (tready),
        .gtwiz_reset_tx_done     (tx_done),
        .gtwiz_userclk_tx_active (clk_act),
        .gtwiz_userdata_tx       (line),
        .link_up                 (link_up),
        .pkt_abort               (pkt_abort),
        .beat_count              (beat_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [79:0] exp_q[$];
    logic [79:0] data_log[$];
    bit          m_in_pkt = 0;
    logic [7:0]  m_idx = '0;
    int          pc = 0;
    bit          prev_lu = 0, lu_s = 0, acc_s = 0, sync_exp = 0;
    int          acc_total = 0;
    int          abort_cnt = 0;

    always begin
        logic [7:0]  t;
        logic [79:0] got;
        @(negedge clk);
        #2;
        if (rst) begin
            m_in_pkt = 0; m_idx = '0; prev_lu = 0; lu_s = 0; acc_s = 0;
            sync_exp = 0; acc_total = 0; exp_q.delete();
        end else begin
            lu_s  = link_up;
            acc_s = tvalid && tready;
            if (lu_s) begin
                pc = prev_lu ? (pc + 1) % P : 0;
                chk("tready_period", 80'(tready), 80'(pc != P-1));
            end
            sync_exp = lu_s && (pc == P-1);
            prev_lu  = lu_s;
            if (acc_s) begin
                t     = m_in_pkt ? (tlast ? 8'hFD : 8'hD0) : (tlast ? 8'hFE : 8'hFB);
                m_idx = m_in_pkt ? m_idx + 8'd1 : 8'd0;
                exp_q.push_back({t, m_idx, tdata});
                m_in_pkt = !tlast;
                acc_total++;
            end
            if (!lu_s) m_in_pkt = 0;
        end
        @(posedge clk);
        #1;
        if (pkt_abort) abort_cnt++;
        if (!rst) begin
            if (acc_s) begin
                got = exp_q.pop_front();
                chk("data_word", line, got);
                data_log.push_back(line);
            end else if (lu_s) begin
                chk(sync_exp ? "sync_word" : "idle_word", line, sync_exp ? SYNC_W : IDLE_W);
            end
        end
    end

    function automatic logic [79:0] log_at(input int i);
        if (i < data_log.size()) return data_log[i];
        return 'x;
    endfunction

    // ---------------- driver helpers (called and returning at a negedge) ----------------
    task automatic send_beat(input logic [63:0] d, input bit last);
        bit acc;
        bit ok;
        ok     = 0;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        for (int k = 0; k < 20 && !ok; k++) begin
            acc = tready;
            @(negedge clk);
            if (acc) ok = 1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_beat timeout observed=no_accept expected=accept");
        end
    endtask

    task automatic bring_up(input string tag);
        int n;
        int syncs;
        n = 0;
        syncs = 0;
        tx_done = 1'b1;
        clk_act = 1'b1;
        while (tready !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (line === SYNC_W) syncs++;
        end
        chk({tag, "_edges"}, 80'(n), 80'(19));
        chk({tag, "_syncs"}, 80'(syncs), 80'(NSYNC));
        chk({tag, "_link_up"}, 80'(link_up), 80'(1));
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n0;
        int fall;
        int ab0;
        bit acc;
        bit got2;
        logic [79:0] w;

        repeat (3) @(negedge clk);
        chk("rst_line", line, IDLE_W);
        chk("rst_tready", 80'(tready), 80'(0));
        chk("rst_link_up", 80'(link_up), 80'(0));
        chk("rst_abort", 80'(pkt_abort), 80'(0));
        chk("rst_beat_count", 80'(beat_count), 80'(0));
        rst = 1'b0;

        // link held down: IDLE, no ready
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            chk("down_line", line, IDLE_W);
            chk("down_tready", 80'(tready), 80'(0));
        end
        @(negedge clk);
        bring_up("bringup");

        // 3-beat packet
        n0 = data_log.size();
        send_beat(64'h1111_1111_1111_1111, 0);
        send_beat(64'h2222_2222_2222_2222, 0);
        send_beat(64'h3333_3333_3333_3333, 1);
        tvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("p3_w0", log_at(n0),   80'hFB00_1111_1111_1111_1111);
        chk("p3_w1", log_at(n0+1), 80'hD001_2222_2222_2222_2222);
        chk("p3_w2", log_at(n0+2), 80'hFD02_3333_3333_3333_3333);
        chk("p3_beat_count", 80'(beat_count), 80'(3));

        // single-beat packet then a 300-beat packet (index wraps)
        n0 = data_log.size();
        send_beat(64'h0000_0000_CAFE_F00D, 1);
        for (int i = 0; i < 300; i++) send_beat({32'h300D_0000, 32'(i)}, i == 299);
        tvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("p300_count", 80'(data_log.size()), 80'(n0 + 301));
        w = log_at(n0);
        chk("sole_hdr", 80'(w[79:64]), 80'(16'hFE00));
        w = log_at(n0 + 1 + 256);
        chk("wrap_hdr", 80'(w[79:64]), 80'(16'hD000));
        w = log_at(n0 + 300);
        chk("p300_last", w, 80'hFD2B_300D_0000_0000_012B);
        chk("beat_count_total", 80'(beat_count), 80'(acc_total));

        // drop tx_done during beat 2 of a 5-beat packet
        n0  = data_log.size();
        ab0 = abort_cnt;
        send_beat(64'hD0D0_0000_0000_0000, 0);
        send_beat(64'hD0D0_0000_0000_0001, 0);
        tvalid  = 1'b1;
        tdata   = 64'hD0D0_0000_0000_0002;
        tlast   = 1'b0;
        tx_done = 1'b0;
        fall = 0;
        got2 = 0;
        for (int k = 1; k <= 6; k++) begin
            acc = tvalid && tready;
            @(posedge clk);
            #1;
            if (acc) begin
                got2   = 1;
                tvalid = 1'b0;
            end
            if (tready === 1'b0 && fall == 0) fall = k;
        end
        tvalid = 1'b0;
        @(negedge clk);
        chk("drop_beat2_taken", 80'(got2), 80'(1));
        chk("drop_tready_fall", 80'(fall >= 1 && fall <= 3), 80'(1));
        repeat (2) @(negedge clk);
        chk("drop_line_idle", line, IDLE_W);
        chk("drop_link_up", 80'(link_up), 80'(0));
        chk("drop_abort_once", 80'(abort_cnt - ab0), 80'(1));
        w = log_at(n0 + 2);
        chk("drop_beat2_hdr", 80'(w[79:64]), 80'(16'hD002));
        bring_up("relink");
        send_beat(64'hD0D0_0000_0000_0003, 0);
        send_beat(64'hD0D0_0000_0000_0004, 1);
        tvalid = 1'b0;
        repeat (2) @(negedge clk);
        w = log_at(n0 + 3);
        chk("relink_sof", 80'(w[79:64]), 80'(16'hFB00));
        w = log_at(n0 + 4);
        chk("relink_eof", 80'(w[79:64]), 80'(16'hFD01));
        chk("abort_total", 80'(abort_cnt - ab0), 80'(1));

        // asynchronous reset mid-packet
        n0 = data_log.size();
        send_beat(64'hEEEE_0000_0000_0000, 0);
        send_beat(64'hEEEE_0000_0000_0001, 0);
        tvalid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_line", line, IDLE_W);
        chk("arst_tready", 80'(tready), 80'(0));
        chk("arst_link_up", 80'(link_up), 80'(0));
        chk("arst_abort", 80'(pkt_abort), 80'(0));
        chk("arst_beat_count", 80'(beat_count), 80'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bring_up("rst_relink");
        n0 = data_log.size();
        send_beat(64'hABCD_0000_0000_0000, 0);
        send_beat(64'hABCD_0000_0000_0001, 1);
        tvalid = 1'b0;
        repeat (2) @(negedge clk);
        w = log_at(n0);
        chk("post_rst_sof", 80'(w[79:64]), 80'(16'hFB00));
        chk("post_rst_beat_count", 80'(beat_count), 80'(2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
